// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the MIPS32 translation unit.
//   - segment base addresses for the unmapped kseg0/kseg1 windows and kseg2
//   - exception code and CP0 TLB operation enums
//   - packed joint-TLB entry (one VPN2 mapping an even/odd page pair)
package mmu_pkg;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_REFILL  = 2'd1,
        EXC_INVALID = 2'd2,
        EXC_MOD     = 2'd3
    } exc_e;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational associative compare of one VPN2/ASID pair against
// every TLB entry. An entry matches when its VPN2 is equal and it is either
// global or carries the same ASID. The valid bits are not part of the match;
// a matching-but-invalid page is reported later as an invalid exception.
// Ports:
//   entries  in   all TLB entries
//   vpn2     in   virtual page-pair number to look up
//   asid     in   address space identifier
//   hit      out  at least one entry matched
//   index    out  lowest matching index (0 when no hit)
module tlb_match
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  tlb_entry_t [TLB_ENTRIES-1:0] entries,
    input  logic [18:0]                  vpn2,
    input  logic [7:0]                   asid,
    output logic                         hit,
    output logic [IDX_W-1:0]             index
);

    // Scanning from the top down lets the lowest matching index overwrite
    // any higher one, giving a fixed priority on duplicate entries.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if ((entries[i].vpn2 == vpn2) && (entries[i].g || (entries[i].asid == asid))) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_mmu.sv
// tlb_mmu: MIPS32 address translation unit.
// kseg0/kseg1 are mapped directly; kuseg/kseg2/kseg3 go through a fully
// associative joint TLB. Lookups are registered (1-cycle latency, one per
// cycle). CP0 TLBP/TLBR/TLBWI/TLBWR complete in one cycle, and the unit keeps
// the CP0 Random and Wired registers.
// Build option: define TLB_MMU_TLB_EN to compile the TLB. Without it mapped
// segments translate identity with no exceptions, TLBP always misses, TLBR
// returns zeros; Random/Wired remain.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   req_valid/req_ready               lookup handshake (ready = !op_valid)
//   req_vaddr, req_write, cur_asid    lookup address, store flag, EntryHi.ASID
//   resp_valid/paddr/uncached/exc     registered lookup result
//   op_valid, op, op_index            CP0 TLB op strobe, opcode, Index
//   op_hi, op_lo0, op_lo1             EntryHi / EntryLo0 / EntryLo1
//   op_done                           op completion pulse
//   probe_miss, probe_index           TLBP result
//   rd_hi, rd_lo0, rd_lo1             TLBR result
//   wired_we, wired_in                Wired register write
//   random_out                        current Random value
module tlb_mmu
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_vaddr,
    input  logic             req_write,
    input  logic [7:0]       cur_asid,
    output logic             resp_valid,
    output logic [31:0]      resp_paddr,
    output logic             resp_uncached,
    output logic [1:0]       resp_exc,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [IDX_W-1:0] op_index,
    input  logic [31:0]      op_hi,
    input  logic [25:0]      op_lo0,
    input  logic [25:0]      op_lo1,
    output logic             op_done,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_index,
    output logic [31:0]      rd_hi,
    output logic [25:0]      rd_lo0,
    output logic [25:0]      rd_lo1,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_in,
    output logic [IDX_W-1:0] random_out
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    tlb_op_e op_kind;
    logic    req_fire_p0;
    assign op_kind     = tlb_op_e'(op);
    assign req_ready   = !op_valid;
    assign req_fire_p0 = req_valid && req_ready;

    // ---------------- Random / Wired ----------------
    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] wired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random_q <= RAND_TOP;
            wired_q  <= '0;
        end else if (wired_we) begin
            wired_q  <= wired_in;
            random_q <= RAND_TOP;
        end else if ((wired_q >= RAND_TOP) || (random_q == wired_q)) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    assign random_out = random_q;

    // ---------------- Stage p0: segment decode and TLB lookup ----------------
    logic  is_kseg0_p0;
    logic  is_kseg1_p0;
    logic [31:0] map_paddr_p0;
    logic  map_unc_p0;
    exc_e  map_exc_p0;

    assign is_kseg0_p0 = (req_vaddr[31:29] == KSEG0_BASE[31:29]);
    assign is_kseg1_p0 = (req_vaddr[31:29] == KSEG1_BASE[31:29]);

`ifdef TLB_MMU_TLB_EN
    tlb_entry_t [TLB_ENTRIES-1:0] entries;
    tlb_entry_t       lk_entry;
    tlb_entry_t       rd_entry;
    tlb_entry_t       wr_entry;
    logic             lk_hit;
    logic             pr_hit;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] pr_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [19:0]      sel_pfn;
    logic [2:0]       sel_c;
    logic             sel_d;
    logic             sel_v;
    logic             unused_bits;

    assign unused_bits = ^op_hi[12:8];

    tlb_match #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_lookup_match (
        .entries (entries),
        .vpn2    (req_vaddr[31:13]),
        .asid    (cur_asid),
        .hit     (lk_hit),
        .index   (lk_idx)
    );

    tlb_match #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe_match (
        .entries (entries),
        .vpn2    (op_hi[31:13]),
        .asid    (op_hi[7:0]),
        .hit     (pr_hit),
        .index   (pr_idx)
    );

    assign lk_entry = entries[lk_idx];
    assign rd_entry = entries[op_index];
    assign wr_idx   = (op_kind == OP_TLBWR) ? random_q : op_index;

    // vaddr[12] picks the odd page of the pair.
    always_comb begin
        sel_pfn = req_vaddr[12] ? lk_entry.pfn1 : lk_entry.pfn0;
        sel_c   = req_vaddr[12] ? lk_entry.c1   : lk_entry.c0;
        sel_d   = req_vaddr[12] ? lk_entry.d1   : lk_entry.d0;
        sel_v   = req_vaddr[12] ? lk_entry.v1   : lk_entry.v0;
        map_exc_p0 = EXC_NONE;
        if (!lk_hit) begin
            map_exc_p0 = EXC_REFILL;
        end else if (!sel_v) begin
            map_exc_p0 = EXC_INVALID;
        end else if (req_write && !sel_d) begin
            map_exc_p0 = EXC_MOD;
        end
        map_paddr_p0 = (map_exc_p0 == EXC_NONE) ? {sel_pfn, req_vaddr[11:0]} : 32'h0;
        map_unc_p0   = (map_exc_p0 == EXC_NONE) && (sel_c == 3'd2);
    end

    // The global bit lives once per pair, so it is the AND of both halves.
    always_comb begin
        wr_entry.vpn2 = op_hi[31:13];
        wr_entry.asid = op_hi[7:0];
        wr_entry.g    = op_lo0[0] & op_lo1[0];
        wr_entry.pfn0 = op_lo0[25:6];
        wr_entry.c0   = op_lo0[5:3];
        wr_entry.d0   = op_lo0[2];
        wr_entry.v0   = op_lo0[1];
        wr_entry.pfn1 = op_lo1[25:6];
        wr_entry.c1   = op_lo1[5:3];
        wr_entry.d1   = op_lo1[2];
        wr_entry.v1   = op_lo1[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries <= '0;
        end else if (op_valid && ((op_kind == OP_TLBWI) || (op_kind == OP_TLBWR))) begin
            entries[wr_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            probe_miss  <= 1'b0;
            probe_index <= '0;
            rd_hi       <= '0;
            rd_lo0      <= '0;
            rd_lo1      <= '0;
        end else if (op_valid) begin
            case (op_kind)
                OP_TLBP: begin
                    probe_miss  <= !pr_hit;
                    probe_index <= pr_hit ? pr_idx : '0;
                end
                OP_TLBR: begin
                    rd_hi  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                    rd_lo0 <= {rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
                    rd_lo1 <= {rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_bits;

    assign unused_bits  = ^{req_write, cur_asid, op_index, op_hi, op_lo0, op_lo1};
    assign map_paddr_p0 = req_vaddr;
    assign map_unc_p0   = 1'b0;
    assign map_exc_p0   = EXC_NONE;
    assign probe_index  = '0;
    assign rd_hi        = '0;
    assign rd_lo0       = '0;
    assign rd_lo1       = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            probe_miss <= 1'b0;
        end else if (op_valid && (op_kind == OP_TLBP)) begin
            probe_miss <= 1'b1;
        end
    end
`endif

    // ---------------- Stage p1: registered response ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid    <= 1'b0;
            resp_paddr    <= '0;
            resp_uncached <= 1'b0;
            resp_exc      <= EXC_NONE;
            op_done       <= 1'b0;
        end else begin
            resp_valid <= req_fire_p0;
            op_done    <= op_valid;
            if (req_fire_p0) begin
                if (is_kseg0_p0) begin
                    resp_paddr    <= req_vaddr - KSEG0_BASE;
                    resp_uncached <= 1'b0;
                    resp_exc      <= EXC_NONE;
                end else if (is_kseg1_p0) begin
                    resp_paddr    <= req_vaddr - KSEG1_BASE;
                    resp_uncached <= 1'b1;
                    resp_exc      <= EXC_NONE;
                end else begin
                    resp_paddr    <= map_paddr_p0;
                    resp_uncached <= map_unc_p0;
                    resp_exc      <= map_exc_p0;
                end
            end
        end
    end

endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

Parametrised MIPS32 address translation unit replacing the fixed segment mapper in the fetch/memory path. It maps kseg0/kseg1 directly and translates kuseg/kseg2/kseg3 through an N-entry fully associative joint TLB with even/odd page pairs. Lookups are registered, with a valid/ready handshake. The unit also executes TLBP/TLBR/TLBWI/TLBWR and maintains the CP0 Random and Wired registers.

## Interface
Parameters:
- TLB_ENTRIES, 16, number of entries; power of two, 4..64
- IDX_W, $clog2(TLB_ENTRIES), index width (derived)

Ports (clock is `clk`, reset is `reset`; one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid / req_ready  in / out  1 / 1  lookup handshake
- req_vaddr  in  32  virtual address
- req_write  in  1  access is a store
- cur_asid  in  8  EntryHi.ASID
- resp_valid  out  1  result valid for exactly one cycle
- resp_paddr  out  32  physical address (0 on exception)
- resp_uncached  out  1  kseg1 access, or mapped access with C==2
- resp_exc  out  2  0 none, 1 refill (no match), 2 invalid, 3 modified
- op_valid  in  1  CP0 TLB op strobe
- op  in  2  0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
- op_index  in  IDX_W  CP0 Index
- op_hi  in  32  EntryHi {VPN2[31:13], 5'b0, ASID[7:0]}
- op_lo0, op_lo1  in  26 each  EntryLo {PFN[25:6], C[5:3], D[2], V[1], G[0]}
- op_done  out  1  op completed; probe/read results valid this cycle
- probe_miss, probe_index  out  1, IDX_W  TLBP result
- rd_hi, rd_lo0, rd_lo1  out  32, 26, 26  TLBR result
- wired_we, wired_in  in  1, IDX_W  Wired register write
- random_out  out  IDX_W  current Random value

## Operation
- kseg0 (0x8000_0000–0x9FFF_FFFF): paddr = vaddr − 0x8000_0000, cached. kseg1 (0xA000_0000–0xBFFF_FFFF): paddr = vaddr − 0xA000_0000, uncached. These segments never raise exceptions.
- Mapped lookup: match when entry.VPN2 == vaddr[31:13] and (G or entry.ASID == cur_asid). vaddr[12] selects lo1 (1) or lo0 (0). paddr = {PFN[19:0], vaddr[11:0]}.
- Exception priority: no match → refill; V==0 → invalid; req_write and D==0 → modified.
- Multiple matches: the lowest index wins. No machine-check exception.
- Writes: TLBWI writes entry op_index. TLBWR writes entry random_out. G is stored as lo0.G & lo1.G.
- TLBP: compares op_hi (VPN2 and ASID, honouring G). On a hit, probe_miss=0 and probe_index=lowest matching index. On a miss, probe_miss=1 and probe_index=0.
- Random: decrements every cycle. When Random equals Wired it reloads TLB_ENTRIES−1 on the next cycle. wired_we sets Wired=wired_in and Random=TLB_ENTRIES−1 in the same cycle. If Wired ≥ TLB_ENTRIES−1, Random stays at TLB_ENTRIES−1.

## Timing
- Reset values: every entry V0=V1=G=D=0; Random=TLB_ENTRIES−1; Wired=0; resp_valid=0; op_done=0; all other outputs 0.
- Lookup latency is 1: a request accepted in cycle t produces resp_valid in t+1. Back-to-back requests sustain one per cycle.
- req_ready = !op_valid. An op takes precedence and a request presented in the same cycle is not accepted.
- Ops complete in 1 cycle: op_done pulses in t+1, and probe/read outputs are registered and hold until the next op.
- A write in cycle t is visible to a lookup accepted in cycle t+1. A lookup accepted in the same cycle as a write is impossible because req_ready is low.
- Reset asserted mid-lookup kills the pending response: resp_valid is 0 the cycle after reset deasserts.

## Configuration
- `TLB_MMU_TLB_EN` defined: full behaviour above.
- `TLB_MMU_TLB_EN` undefined:
  - no entry storage is compiled.
  - kuseg/kseg2/kseg3 map identity with resp_exc=0 and resp_uncached=0.
  - ops still pulse op_done; probe_miss=1; rd_* = 0.
  - Random/Wired logic is retained.

## Structure
- Package `mmu_pkg`:
  - segment base constants (KSEG0_BASE, KSEG1_BASE, KSEG2_BASE)
  - exception code enum (EXC_NONE/REFILL/INVALID/MOD)
  - TLB op enum
  - entry struct {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
- Sub-module `tlb_match`: combinational compare of one VPN2/ASID against all entries. It returns a hit flag and the lowest matching index, and is instantiated twice (lookup path and probe path).

## Test plan
- After reset, lookup 0x9000_1234 → next cycle resp_valid=1, paddr 0x1000_1234, uncached=0, exc=0. Lookup 0xBFC0_0000 → paddr 0x1FC0_0000, uncached=1.
- TLBWI idx 3: hi VPN2=0x00400>>1 (0x0040_0000), ASID 5, lo0 PFN 0x123 V=1 D=0, lo1 V=0. Then:
  - load 0x0040_0ABC, asid 5 → paddr 0x0012_3ABC
  - store to the same address → exc=3
  - load 0x0040_1000 → exc=2
  - asid 6 → exc=1
- Set G on both halves and repeat the load with asid 6 → hit. TLBP of same VPN2 → probe_miss=0, probe_index=3. TLBP of 0x0080_0000 → probe_miss=1.
- Wired=4 → Random reads 15, counts down to 4, then reloads 15. TLBWR lands at the sampled random_out, verified with TLBR.
- Duplicate match at indices 2 and 7 → the result uses entry 2.
- op_valid and req_valid in the same cycle → req_ready=0 and the op executes. A lookup in the next cycle sees the new entry. Reset asserted with a lookup in flight → no resp_valid.
